serial_subtractor: RTL

- Bit-serial unsigned subtractor: computes diff = a - b over WIDTH bits, LSB first, one bit per clock.
- Subtraction counterpart to the team's combinational adder cells.
- Built from a borrow-propagating full-subtractor bit cell, a borrow flop and shift registers.
- Used in area-constrained datapaths; valid/ready handshake on both input and result sides.

---
 rtl/serial_sub_pkg.sv | 15 +
 rtl/full_subtractor_bit.sv | 23 ++
 rtl/serial_subtractor.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/serial_sub_pkg.sv
// rtl/serial_sub_pkg.sv - shared state encoding and counter sizing for serial_subtractor
package serial_sub_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    // Bit counter needs to reach WIDTH-1; never narrower than one bit.
    function automatic int cnt_width(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/full_subtractor_bit.sv
// rtl/full_subtractor_bit.sv - one-bit borrow-propagating full subtractor from two half-subtractor stages
module full_subtractor_bit (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic diff,
    output logic bout
);

    logic d1;
    logic b1;
    logic b2;

    // First stage subtracts b from a, second stage subtracts the incoming borrow.
    always_comb begin
        d1   = a ^ b;
        b1   = ~a & b;
        diff = d1 ^ bin;
        b2   = ~d1 & bin;
        bout = b1 | b2;
    end

endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial unsigned subtractor, LSB first; zero/ovf flags with SERIAL_SUBTRACTOR_FLAGS_EN
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
`ifdef SERIAL_SUBTRACTOR_FLAGS_EN
    ,
    output logic             zero,
    output logic             ovf
`endif
);

    localparam int             CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] diff_sr;
    logic [WIDTH-1:0] diff_shift;
    logic             bflop;
    logic [CW-1:0]    cnt;
    logic             cell_d;
    logic             cell_b;

    full_subtractor_bit u_cell (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .bin  (bflop),
        .diff (cell_d),
        .bout (cell_b)
    );

    // Next value of the result shifter: new difference bit enters at the MSB.
    always_comb begin
        diff_shift            = diff_sr >> 1;
        diff_shift[WIDTH-1]   = cell_d;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nx = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (cnt == LAST) begin
                    state_nx = S_DONE;
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nx = S_IDLE;
                end
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // Operand latch, serial datapath and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr    <= '0;
            b_sr    <= '0;
            diff_sr <= '0;
            bflop   <= 1'b0;
            cnt     <= '0;
            diff    <= '0;
            borrow  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        a_sr  <= a;
                        b_sr  <= b;
                        bflop <= 1'b0;
                        cnt   <= '0;
                    end
                end
                S_SHIFT: begin
                    a_sr    <= a_sr >> 1;
                    b_sr    <= b_sr >> 1;
                    diff_sr <= diff_shift;
                    bflop   <= cell_b;
                    cnt     <= cnt + 1'b1;
                    // Publish only on the final bit so diff/borrow hold the previous result until then.
                    if (cnt == LAST) begin
                        diff   <= diff_shift;
                        borrow <= cell_b;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef SERIAL_SUBTRACTOR_FLAGS_EN
    logic a_msb;
    logic b_msb;

    // Operand sign bits are kept because the shifters lose them; flags update with the result.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_msb <= 1'b0;
            b_msb <= 1'b0;
            zero  <= 1'b0;
            ovf   <= 1'b0;
        end else if (state == S_IDLE && in_valid) begin
            a_msb <= a[WIDTH-1];
            b_msb <= b[WIDTH-1];
        end else if (state == S_SHIFT && cnt == LAST) begin
            zero <= (diff_shift == '0);
            ovf  <= (a_msb ^ b_msb) & (a_msb ^ cell_d);
        end
    end
`endif

endmodule
